irq_source_ctrl: RTL and testbench

Interrupt request source feeding the pipelined CPU's interrupt inputs. Takes raw board buttons and synchronizes and debounces them. Latches rising edges as pending requests, then presents one prioritized, masked request to the CPU. Holds that request until the CPU acknowledges it by ID. The pending vector drives the board request LEDs.

---
 rtl/irq_source_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_source_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// Button-driven interrupt source: synchronizes and debounces each line, then latches presses as pending.
// Presents the highest-priority enabled request to the CPU and holds it until acknowledged by ID.
module irq_source_ctrl #(
    parameter int N_IRQ     = 3,
    parameter int ID_W      = 2,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] btn,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             ack,
    input  logic [ID_W-1:0]  ack_id,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic             ack_err
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_t;

    logic [N_IRQ-1:0] sync1_q, sync1_d;
    logic [N_IRQ-1:0] sync2_q, sync2_d;
    logic [N_IRQ-1:0] db_q, db_d;
    logic [N_IRQ-1:0] db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q [N_IRQ];
    logic [CNT_W-1:0] cnt_d [N_IRQ];
    logic [N_IRQ-1:0] pending_q, pending_d;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             ack_err_q, ack_err_d;

    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] sel;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  top_id;
    logic             cur_ok;
    logic             ack_hit;

    // Synchronizer, debounce and edge latch
    always_comb begin
        sync1_d   = btn;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        for (int i = 0; i < N_IRQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // A new press beats a same-cycle acknowledge of that line.
        pending_d = (pending_q & ~clr) | (db_q & ~db_prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            pending_q <= '0;
            for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            pending_q <= pending_d;
            for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Request arbitration
    always_comb begin
        eligible = pending_q & irq_mask;
        top_id   = '0;
        sel      = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eligible[i]) top_id = ID_W'(i);
            sel[i] = (irq_id_q == ID_W'(i));
        end
        cur_ok  = |(eligible & sel);
        ack_hit = ack && (state_q == REQ) && (ack_id == irq_id_q);
        clr     = ack_hit ? sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = REQ;
            REQ:     if (ack_hit || !cur_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ID is captured only on entry to REQ, so later higher-priority presses wait their turn.
    always_comb begin
        irq_d     = (state_d == REQ);
        irq_id_d  = irq_id_q;
        if (state_q == IDLE && state_d == REQ) irq_id_d = top_id;
        ack_err_d = ack && !ack_hit;
    end

    assign irq     = irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed walk through the request-controller scenarios followed by randomized traffic
// compared against a window-based behavioural model.
module tb_irq_source_ctrl;

    localparam int N  = 3;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] irq_mask;
    logic         ack;
    logic [1:0]   ack_id;
    logic         irq;
    logic [1:0]   irq_id;
    logic [N-1:0] pending;
    logic         ack_err;

    int checks   = 0;
    int failures = 0;

    irq_source_ctrl #(.N_IRQ(N), .ID_W(2), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn(btn), .irq_mask(irq_mask), .ack(ack), .ack_id(ack_id),
        .irq(irq), .irq_id(irq_id), .pending(pending), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] m_pend, m_d, m_rose;
    logic         m_req, m_ackerr;
    logic [1:0]   m_id;
    int           m_last_flip [N];
    int           cyc;
    logic [N-1:0] btn_at [4096];
    int           hold [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic s_before(input int k, input int i);
        return (k >= 3) ? btn_at[k-2][i] : 1'b0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_d = '0; m_rose = '0;
        m_req = 1'b0; m_ackerr = 1'b0; m_id = '0;
        cyc = 0;
        for (int i = 0; i < N; i++) m_last_flip[i] = 0;
    endtask

    // One clock edge of the reference: debounced level flips only after DB consecutive
    // disagreeing synchronized samples, none of which precede the previous flip.
    task automatic model_step();
        logic [N-1:0] clr, e;
        logic         n_req;
        logic [1:0]   n_id;
        bit           all_diff;
        cyc++;
        btn_at[cyc] = btn;
        clr = '0;
        e = m_pend & irq_mask;
        n_req = m_req;
        n_id = m_id;
        m_ackerr = ack && (!m_req || ack_id != m_id);
        if (!m_req) begin
            if (e != 0) begin
                n_req = 1'b1;
                for (int i = 0; i < N; i++) if (e[i]) n_id = 2'(i);
            end
        end else if (ack && ack_id == m_id) begin
            clr[m_id] = 1'b1;
            n_req = 1'b0;
        end else if (!irq_mask[m_id] || !m_pend[m_id]) begin
            n_req = 1'b0;
        end
        m_req = n_req;
        m_id = n_id;
        m_pend = (m_pend & ~clr) | m_rose;
        for (int i = 0; i < N; i++) begin
            m_rose[i] = 1'b0;
            if (m_last_flip[i] <= cyc - DB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (s_before(cyc - j, i) == m_d[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_d[i] = ~m_d[i];
                    m_last_flip[i] = cyc;
                    m_rose[i] = m_d[i];
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn = '0; irq_mask = 3'b111; ack = 1'b0; ack_id = '0;
        tick(); tick();
        chk("reset_irq", irq, 0);
        chk("reset_id", irq_id, 0);
        chk("reset_pending", pending, 0);
        chk("reset_ackerr", ack_err, 0);
        rst = 1'b0;
        tick();

        // Short glitch must be filtered
        btn = 3'b001;
        repeat (3) tick();
        btn = 3'b000;
        repeat (10) tick();
        chk("glitch_pending", pending, 0);
        chk("glitch_irq", irq, 0);

        // Debounced press: pending after 7 edges, irq one edge later
        btn = 3'b001;
        repeat (6) tick();
        chk("press_pending_early", pending, 0);
        tick();
        chk("press_pending", pending, 3'b001);
        chk("press_irq_early", irq, 0);
        tick();
        chk("press_irq", irq, 1);
        chk("press_id", irq_id, 0);
        repeat (2) tick();
        btn = 3'b000;

        // Higher priority arrives during REQ: ID frozen
        btn = 3'b100;
        repeat (9) tick();
        chk("freeze_pending", pending, 3'b101);
        chk("freeze_irq", irq, 1);
        chk("freeze_id", irq_id, 0);
        btn = 3'b000;
        ack = 1'b1; ack_id = 2'd0;
        tick();
        ack = 1'b0;
        chk("ack0_pending", pending, 3'b100);
        chk("ack0_irq", irq, 0);
        chk("ack0_err", ack_err, 0);
        tick();
        chk("next_irq", irq, 1);
        chk("next_id", irq_id, 2);
        ack = 1'b1; ack_id = 2'd2;
        tick();
        ack = 1'b0;
        chk("ack2_pending", pending, 0);
        chk("ack2_irq", irq, 0);

        // Bad ack while in REQ(id 1), then ack while idle
        btn = 3'b010;
        repeat (8) tick();
        btn = 3'b000;
        chk("req1_irq", irq, 1);
        chk("req1_id", irq_id, 1);
        ack = 1'b1; ack_id = 2'd2;
        tick();
        ack = 1'b0;
        chk("badack_err", ack_err, 1);
        chk("badack_pending", pending, 3'b010);
        chk("badack_irq", irq, 1);
        chk("badack_id", irq_id, 1);
        tick();
        chk("badack_err_drop", ack_err, 0);
        ack = 1'b1; ack_id = 2'd3;
        tick();
        ack = 1'b0;
        chk("oorack_err", ack_err, 1);
        chk("oorack_irq", irq, 1);
        ack = 1'b1; ack_id = 2'd1;
        tick();
        ack = 1'b0;
        chk("ack1_err", ack_err, 0);
        chk("ack1_pending", pending, 0);
        chk("ack1_irq", irq, 0);
        ack = 1'b1; ack_id = 2'd0;
        tick();
        ack = 1'b0;
        chk("idleack_err", ack_err, 1);
        chk("idleack_pending", pending, 0);
        chk("idleack_irq", irq, 0);
        tick();
        chk("idleack_err_drop", ack_err, 0);
        repeat (8) tick();

        // Masked line latches but does not request
        irq_mask = 3'b011;
        btn = 3'b100;
        repeat (9) tick();
        btn = 3'b000;
        chk("mask_pending", pending, 3'b100);
        chk("mask_irq", irq, 0);
        irq_mask = 3'b111;
        tick();
        chk("unmask_irq", irq, 1);
        chk("unmask_id", irq_id, 2);
        irq_mask = 3'b011;
        tick();
        chk("withdraw_irq", irq, 0);
        chk("withdraw_pending", pending, 3'b100);
        chk("withdraw_err", ack_err, 0);
        irq_mask = 3'b111;
        tick();
        chk("remask_irq", irq, 1);
        ack = 1'b1; ack_id = 2'd2;
        tick();
        ack = 1'b0;
        chk("mask_clear", pending, 0);
        repeat (8) tick();

        // Set/clear collision on line 1
        btn = 3'b010;
        repeat (8) tick();
        btn = 3'b000;
        chk("coll_req_id", irq_id, 1);
        repeat (8) tick();
        btn = 3'b010;
        repeat (6) tick();
        chk("coll_pre_pending", pending, 3'b010);
        chk("coll_pre_irq", irq, 1);
        ack = 1'b1; ack_id = 2'd1;
        tick();
        ack = 1'b0;
        chk("coll_pending", pending, 3'b010);
        chk("coll_irq_gap", irq, 0);
        chk("coll_err", ack_err, 0);
        tick();
        chk("coll_irq_again", irq, 1);
        chk("coll_id", irq_id, 1);

        // Asynchronous reset mid-request with btn[1] held through release
        #2 rst = 1'b1;
        #1;
        chk("arst_irq", irq, 0);
        chk("arst_id", irq_id, 0);
        chk("arst_pending", pending, 0);
        chk("arst_err", ack_err, 0);
        tick(); tick();
        #2 rst = 1'b0;
        repeat (6) tick();
        chk("held_pending_early", pending, 0);
        tick();
        chk("held_pending", pending, 3'b010);
        tick();
        chk("held_irq", irq, 1);
        chk("held_id", irq_id, 1);

        // Randomized traffic against the reference model
        btn = '0; ack = 1'b0; irq_mask = 3'b111;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn[i] = ~btn[i];
                    hold[i] = $urandom_range(1, 12);
                end
            end
            if ($urandom_range(0, 19) == 0) irq_mask = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                ack = 1'b1;
                ack_id = (m_req && $urandom_range(0, 3) != 0) ? m_id : 2'($urandom_range(0, 3));
            end else begin
                ack = 1'b0;
            end
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_pending", pending, m_pend);
            chk("rnd_irq", irq, m_req);
            chk("rnd_ackerr", ack_err, m_ackerr);
            if (m_req) chk("rnd_id", irq_id, m_id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
